// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: operation encodings and controller states shared by the universal register
package shift_reg_pkg;
  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_SHL  = 3'd1;
  localparam logic [2:0] M_SHR  = 3'd2;
  localparam logic [2:0] M_ROL  = 3'd3;
  localparam logic [2:0] M_ROR  = 3'd4;
  localparam logic [2:0] M_LOAD = 3'd5;
  localparam logic [2:0] M_CLR  = 3'd6;
  localparam logic [2:0] M_SET  = 3'd7;
  typedef enum logic {S_IDLE, S_BURST} state_t;
endpackage

// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: burst controller choosing which operation the datapath applies each edge
module shift_reg_ctrl
  import shift_reg_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             START,
  input  logic [2:0]       MODE,
  input  logic [CNT_W-1:0] COUNT,
  output logic             BUSY,
  output logic             DONE,
  output logic             op_valid,
  output logic [2:0]       op_sel
);
  state_t           state_q;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] rem_q;
  logic             done_q;
  // IDLE latches a burst request; BURST counts down enabled ops and pulses DONE after the last one
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q    <= M_HOLD;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else if (state_q == S_IDLE) begin
      done_q <= EN && START && COUNT == '0;
      if (EN && START && COUNT != '0) begin
        op_q    <= MODE;
        rem_q   <= COUNT;
        state_q <= S_BURST;
      end
    end else begin
      done_q <= EN && rem_q == CNT_W'(1);
      if (EN) begin
        rem_q <= rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) begin
          state_q <= S_IDLE;
          op_q    <= M_HOLD;
        end
      end
    end
  end
  assign BUSY     = state_q == S_BURST;
  assign DONE     = done_q;
  assign op_valid = BUSY ? EN : EN && !START;
  assign op_sel   = BUSY ? op_q : MODE;
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift/rotate/load register with counted-burst control
module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIL,
  input  logic             SIR,
  input  logic             START,
  input  logic [CNT_W-1:0] COUNT,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB,
  output logic             SOL,
  output logic             SOR,
  output logic             BUSY,
  output logic             DONE
);
  logic [WIDTH-1:0] q_q, q_d;
  logic             op_valid;
  logic [2:0]       op_sel;
  shift_reg_ctrl #(.CNT_W(CNT_W)) u_ctrl (
    .CLK(CLK), .RST(RST), .EN(EN), .START(START), .MODE(MODE), .COUNT(COUNT),
    .BUSY(BUSY), .DONE(DONE), .op_valid(op_valid), .op_sel(op_sel)
  );
  // next word for the selected operation; anything not selected holds
  always_comb begin
    q_d = q_q;
    if (op_valid)
      case (op_sel)
        M_SHL:   q_d = {q_q[WIDTH-2:0], SIL};
        M_SHR:   q_d = {SIR, q_q[WIDTH-1:1]};
        M_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        M_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
        M_LOAD:  q_d = D;
        M_CLR:   q_d = '0;
        M_SET:   q_d = '1;
        default: q_d = q_q;
      endcase
  end
  // storage register
  always_ff @(posedge CLK) q_q <= RST ? '0 : q_d;
  assign Q   = q_q;
  assign QB  = ~q_q;
  assign SOL = q_q[WIDTH-1];
  assign SOR = q_q[0];
endmodule
